reg_file_scoreboard: RTL and testbench
======================================

REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 Parameter DATA_W, default 64: register data width in bits.
REQ-002 Parameter ADDR_W, default 5: register index width; depth is 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 3: number of independent read ports.
REQ-004 Parameter ZERO_IDX, default 31: hardwired-zero register index.
REQ-005 Parameter BYPASS, default 1: 1 forwards same-cycle write data to the read ports; 0 does not.
REQ-006 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 i_rst  in  1  asynchronous, active-high reset.
REQ-008 i_rdAddr  in  NUM_RD*ADDR_W  packed read indices; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-009 o_rdData  out  NUM_RD*DATA_W  packed read data, same packing rule.
REQ-010 o_rdReady  out  NUM_RD  per-port operand-valid flag.
REQ-011 i_regWr  in  1  write enable.
REQ-012 i_wrReg  in  ADDR_W  write index.
REQ-013 i_dataWr  in  DATA_W  write data.
REQ-014 i_issue  in  1  an instruction reserves destination i_issueReg.
REQ-015 i_issueReg  in  ADDR_W  destination index being reserved.
REQ-016 o_issueStall  out  1  reservation refused this cycle (WAW hazard).
REQ-017 o_busy  out  2**ADDR_W  scoreboard busy vector, bit n = register n pending.

Function
REQ-018 Write: at posedge with i_regWr=1 and i_wrReg!=ZERO_IDX, regs[i_wrReg] <= i_dataWr and busy[i_wrReg] <= 0; writes to ZERO_IDX are discarded.
REQ-019 Read is combinational, zero latency; per port, priority: addr==ZERO_IDX -> data 0, ready 1; else BYPASS=1 and i_regWr=1 and addr==i_wrReg -> data i_dataWr, ready 1; else data regs[addr], ready !busy[addr].
REQ-020 Issue: o_issueStall = i_issue & busy[i_issueReg] & !(i_regWr & i_wrReg==i_issueReg) & (i_issueReg!=ZERO_IDX).
REQ-021 At posedge with i_issue=1, o_issueStall=0, i_issueReg!=ZERO_IDX: busy[i_issueReg] <= 1.
REQ-022 Issue and write to the same index in the same cycle: data is written and busy ends 1 (issue wins over clear).
REQ-023 Issue to ZERO_IDX: no state change, no stall.
REQ-024 Stalled issue leaves busy unchanged; requester holds i_issue until o_issueStall=0.
REQ-025 Write to a non-busy register is legal; busy stays 0.
REQ-026 Any number of read ports may address the same register concurrently; all return identical data and ready.
REQ-027 busy[ZERO_IDX] is constant 0.

Reset
REQ-028 i_rst=1 asynchronously clears all registers to 0 and all busy bits to 0, overriding any concurrent write or issue.
REQ-029 During reset: o_rdData = 0 on every port except the BYPASS forward path, o_rdReady = all ones except bypass-independent busy=0 cases (i.e. all ones), o_busy = 0, o_issueStall = 0 when no register is busy.
REQ-030 First write/issue takes effect at the first rising edge after i_rst deasserts.

Structure
REQ-031 Package reg_file_pkg holds default DATA_W, ADDR_W, NUM_RD, ZERO_IDX and a localparam DEPTH = 2**ADDR_W helper.
REQ-032 Sub-module rf_scoreboard owns the busy vector (set on issue, clear on write, stall logic); reg_file_scoreboard instantiates it and the storage array with a generate loop over NUM_RD read ports.

Verification
REQ-033 Reset then read X3, X31 on ports 0/1 -> data 0x0/0x0, ready 1/1, o_busy=0.
REQ-034 Write X5=0xDEADBEEF_00000001 with port0 reading X5, BYPASS=1 -> same-cycle data 0xDEADBEEF_00000001, ready 1; next cycle stored value identical.
REQ-035 Issue X7; next cycle read X7 -> ready 0, o_busy[7]=1; issue X7 again -> o_issueStall=1; write X7=0x42 -> next cycle ready 1, data 0x42, busy[7]=0.
REQ-036 Issue X9 and write X9=0x11 same cycle -> next cycle data 0x11, busy[9]=1, ready 0; write X31=0xFF -> read X31 returns 0.
REQ-037 Issue X2, then assert i_rst mid-cycle -> busy[2] clears immediately without clock edge, read X2 data 0, ready 1.
REQ-038 BYPASS=0 build: write X4=0x99 with port2 reading X4 -> same-cycle data is old value 0, next cycle 0x99.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared defaults for the scoreboarded register file.
package reg_file_pkg;

  localparam int DATA_W_DEF   = 64;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_RD_DEF   = 3;
  localparam int ZERO_IDX_DEF = 31;

  // Number of registers addressed by an index of the given width.
  function automatic int depth_of(input int addr_w);
    return 2 ** addr_w;
  endfunction

  localparam int DEPTH = depth_of(ADDR_W_DEF);

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: issue reserves a destination, writeback releases it,
// and a reservation of a still-pending register is refused (WAW stall).
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_IDX = ZERO_IDX_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_regWr,
  input  logic [ADDR_W-1:0]         i_wrReg,
  input  logic                      i_issue,
  input  logic [ADDR_W-1:0]         i_issueReg,
  output logic                      o_issueStall,
  output logic [depth_of(ADDR_W)-1:0] o_busy
);

  localparam int NREGS = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_IDX);

  logic [NREGS-1:0] busy;
  logic             wr_ok;
  logic             issue_ok;

  assign wr_ok = i_regWr && (i_wrReg != ZERO);

  // A writeback to the very register being reserved resolves the hazard this cycle.
  assign o_issueStall = i_issue && busy[i_issueReg]
                        && !(i_regWr && (i_wrReg == i_issueReg))
                        && (i_issueReg != ZERO);

  assign issue_ok = i_issue && !o_issueStall && (i_issueReg != ZERO);

  // Clear on write, then set on issue so a same-cycle issue wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy <= '0;
    end else begin
      if (wr_ok)    busy[i_wrReg]    <= 1'b0;
      if (issue_ok) busy[i_issueReg] <= 1'b1;
    end
  end

  assign o_busy = busy;

endmodule

// File: rtl/reg_file_scoreboard.sv
// Multi-port register file with a hardwired-zero register, optional
// write-to-read forwarding and a busy scoreboard for operand readiness.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_IDX = ZERO_IDX_DEF,
  parameter int BYPASS   = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_RD*ADDR_W-1:0]    i_rdAddr,
  output logic [NUM_RD*DATA_W-1:0]    o_rdData,
  output logic [NUM_RD-1:0]           o_rdReady,
  input  logic                        i_regWr,
  input  logic [ADDR_W-1:0]           i_wrReg,
  input  logic [DATA_W-1:0]           i_dataWr,
  input  logic                        i_issue,
  input  logic [ADDR_W-1:0]           i_issueReg,
  output logic                        o_issueStall,
  output logic [depth_of(ADDR_W)-1:0] o_busy
);

  localparam int NREGS = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_ok;

  assign wr_ok = i_regWr && (i_wrReg != ZERO);

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_IDX (ZERO_IDX)
  ) u_sb (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_regWr      (i_regWr),
    .i_wrReg      (i_wrReg),
    .i_issue      (i_issue),
    .i_issueReg   (i_issueReg),
    .o_issueStall (o_issueStall),
    .o_busy       (o_busy)
  );

  // Storage array; the zero register slot is never written.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int n = 0; n < NREGS; n++) regs[n] <= '0;
    end else if (wr_ok) begin
      regs[i_wrReg] <= i_dataWr;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rdy;

    assign addr = i_rdAddr[k*ADDR_W +: ADDR_W];

    // Zero register first, then forwarded write data, then stored value.
    always_comb begin
      data = regs[addr];
      rdy  = !o_busy[addr];
      if (addr == ZERO) begin
        data = '0;
        rdy  = 1'b1;
      end else if ((BYPASS != 0) && i_regWr && (addr == i_wrReg)) begin
        data = i_dataWr;
        rdy  = 1'b1;
      end
    end

    assign o_rdData[k*DATA_W +: DATA_W] = data;
    assign o_rdReady[k]                 = rdy;
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed scoreboard bench: expectations are queued as stimulus is applied
// and popped in order as DUT outputs are sampled between clock edges.
module tb_reg_file_scoreboard;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR*AW-1:0] rd_addr;
  logic           reg_wr;
  logic [AW-1:0]  wr_reg;
  logic [DW-1:0]  data_wr;
  logic           issue;
  logic [AW-1:0]  issue_reg;

  logic [NR*DW-1:0] rd_data,  rd_data_nb;
  logic [NR-1:0]    rd_rdy,   rd_rdy_nb;
  logic             stall,    stall_nb;
  logic [31:0]      busy,     busy_nb;

  int n_checks = 0;
  int n_fail   = 0;
  string         tag_q[$];
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  reg_file_scoreboard #(.BYPASS(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_rdAddr(rd_addr), .o_rdData(rd_data),
    .o_rdReady(rd_rdy), .i_regWr(reg_wr), .i_wrReg(wr_reg), .i_dataWr(data_wr),
    .i_issue(issue), .i_issueReg(issue_reg), .o_issueStall(stall), .o_busy(busy)
  );

  reg_file_scoreboard #(.BYPASS(0)) dut_nb (
    .i_clk(clk), .i_rst(rst), .i_rdAddr(rd_addr), .o_rdData(rd_data_nb),
    .o_rdReady(rd_rdy_nb), .i_regWr(reg_wr), .i_wrReg(wr_reg), .i_dataWr(data_wr),
    .i_issue(issue), .i_issueReg(issue_reg), .o_issueStall(stall_nb), .o_busy(busy_nb)
  );

  task automatic expect_v(input string tag, input logic [DW-1:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [DW-1:0] obs);
    string         t;
    logic [DW-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_underflow observed %h expected <none>", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s observed %h expected %h", t, obs, e);
      end
    end
  endtask

  function automatic logic [DW-1:0] d(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] dnb(input int k);
    return rd_data_nb[k*DW +: DW];
  endfunction

  function automatic logic [NR*AW-1:0] pack3(input logic [AW-1:0] a2, a1, a0);
    return {a2, a1, a0};
  endfunction

  initial begin
    rst = 1'b0; reg_wr = 1'b0; wr_reg = '0; data_wr = '0;
    issue = 1'b0; issue_reg = '0; rd_addr = '0;
    #1 rst = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    rd_addr = pack3(5'd0, 5'd31, 5'd3);
    #1;
    expect_v("rst_busy", 0);  expect_v("rst_x3_data", 0); expect_v("rst_x31_data", 0);
    expect_v("rst_ready", 64'h7); expect_v("rst_stall", 0);
    check(DW'(busy)); check(d(0)); check(d(1)); check(DW'(rd_rdy)); check(DW'(stall));

    @(negedge clk);
    rst = 1'b0;

    // Write X5 with forwarding
    @(negedge clk);
    reg_wr = 1'b1; wr_reg = 5'd5; data_wr = 64'hDEADBEEF_00000001;
    rd_addr = pack3(5'd0, 5'd0, 5'd5);
    #1;
    expect_v("x5_bypass_data", 64'hDEADBEEF_00000001); expect_v("x5_bypass_rdy", 1);
    expect_v("x5_nb_old_data", 0);
    check(d(0)); check(DW'(rd_rdy[0])); check(dnb(0));

    @(negedge clk);
    reg_wr = 1'b0;
    rd_addr = pack3(5'd5, 5'd5, 5'd5);
    #1;
    expect_v("x5_stored_p0", 64'hDEADBEEF_00000001);
    expect_v("x5_stored_p1", 64'hDEADBEEF_00000001);
    expect_v("x5_stored_p2", 64'hDEADBEEF_00000001);
    expect_v("x5_ready_all", 64'h7);
    check(d(0)); check(d(1)); check(d(2)); check(DW'(rd_rdy));

    // Issue X7, stall on re-issue, release by write
    @(negedge clk);
    issue = 1'b1; issue_reg = 5'd7;
    #1;
    expect_v("x7_first_issue_stall", 0);
    check(DW'(stall));

    @(negedge clk);
    rd_addr = pack3(5'd0, 5'd0, 5'd7);
    #1;
    expect_v("x7_busy_rdy", 0); expect_v("x7_busy_vec", 32'h0000_0080); expect_v("x7_waw_stall", 1);
    check(DW'(rd_rdy[0])); check(DW'(busy)); check(DW'(stall));

    @(negedge clk);
    issue = 1'b0;
    #1;
    expect_v("x7_stalled_busy_kept", 32'h0000_0080); expect_v("x7_no_issue_stall", 0);
    check(DW'(busy)); check(DW'(stall));

    @(negedge clk);
    reg_wr = 1'b1; wr_reg = 5'd7; data_wr = 64'h42;
    issue = 1'b1; issue_reg = 5'd7;
    #1;
    expect_v("x7_wr_resolves_stall", 0); expect_v("x7_wr_bypass_data", 64'h42);
    expect_v("x7_nb_rdy_busy", 0);
    check(DW'(stall)); check(d(0)); check(DW'(rd_rdy_nb[0]));
    issue = 1'b0;
    #1;

    @(negedge clk);
    reg_wr = 1'b0;
    #1;
    expect_v("x7_after_wr_data", 64'h42); expect_v("x7_after_wr_rdy", 1);
    expect_v("x7_after_wr_busy", 0);
    check(d(0)); check(DW'(rd_rdy[0])); check(DW'(busy));

    // Issue and write X9 in the same cycle: issue wins
    @(negedge clk);
    issue = 1'b1; issue_reg = 5'd9;
    reg_wr = 1'b1; wr_reg = 5'd9; data_wr = 64'h11;
    rd_addr = pack3(5'd0, 5'd0, 5'd9);
    #1;
    expect_v("x9_same_cycle_stall", 0);
    check(DW'(stall));

    @(negedge clk);
    issue = 1'b0; reg_wr = 1'b0;
    #1;
    expect_v("x9_data", 64'h11); expect_v("x9_rdy", 0); expect_v("x9_busy", 32'h0000_0200);
    check(d(0)); check(DW'(rd_rdy[0])); check(DW'(busy));

    // Zero register: write discarded, issue ignored
    @(negedge clk);
    reg_wr = 1'b1; wr_reg = 5'd31; data_wr = 64'hFF;
    issue = 1'b1; issue_reg = 5'd31;
    rd_addr = pack3(5'd0, 5'd31, 5'd9);
    #1;
    expect_v("x31_wr_read_zero", 0); expect_v("x31_rdy", 1); expect_v("x31_issue_stall", 0);
    check(d(1)); check(DW'(rd_rdy[1])); check(DW'(stall));

    @(negedge clk);
    reg_wr = 1'b0; issue = 1'b0;
    #1;
    expect_v("x31_after_data", 0); expect_v("x31_busy_unchanged", 32'h0000_0200);
    check(d(1)); check(DW'(busy));

    // Issue X2, then asynchronous reset mid-cycle
    @(negedge clk);
    issue = 1'b1; issue_reg = 5'd2;
    @(negedge clk);
    issue = 1'b0;
    rd_addr = pack3(5'd5, 5'd9, 5'd2);
    #1;
    expect_v("x2_busy_before_rst", 32'h0000_0204);
    check(DW'(busy));
    #1 rst = 1'b1;
    #1;
    expect_v("rst_mid_busy", 0); expect_v("rst_mid_x2_data", 0); expect_v("rst_mid_ready", 64'h7);
    expect_v("rst_mid_x5_data", 0); expect_v("rst_mid_x9_data", 0); expect_v("rst_mid_nb_busy", 0);
    check(DW'(busy)); check(d(0)); check(DW'(rd_rdy)); check(d(2)); check(d(1)); check(DW'(busy_nb));

    @(negedge clk);
    rst = 1'b0;

    // No-forwarding build: port 2 sees old value during the write
    @(negedge clk);
    reg_wr = 1'b1; wr_reg = 5'd4; data_wr = 64'h99;
    rd_addr = pack3(5'd4, 5'd0, 5'd0);
    #1;
    expect_v("x4_nb_same_cycle", 0); expect_v("x4_nb_rdy", 1); expect_v("x4_byp_same_cycle", 64'h99);
    check(dnb(2)); check(DW'(rd_rdy_nb[2])); check(d(2));

    @(negedge clk);
    reg_wr = 1'b0;
    #1;
    expect_v("x4_nb_next_cycle", 64'h99);
    check(dnb(2));

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover observed %0d expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
